// File: rtl/hazard_unit_pkg.sv
// Shared constants, tracking-entry type and helpers for the hazard unit.
// Build option: HAZARD_FWD_EN (full forwarding); undefined = pure interlock.
package hazard_unit_pkg;

  localparam int REGW = 5;
  localparam int TW   = 2;

  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_E   = 2'd1;
  localparam logic [1:0] FWD_M   = 2'd2;
  localparam logic [1:0] FWD_W   = 2'd3;

  localparam logic [TW-1:0]   TUSE_NONE = 2'd3;
  localparam logic [REGW-1:0] REG_ZERO  = '0;

  // Tnew handling applied when an entry is loaded.
  localparam int TN_KEEP = 0;
  localparam int TN_DEC  = 1;
  localparam int TN_CLR  = 2;

  typedef struct packed {
    logic            wen;
    logic [REGW-1:0] dst;
    logic [TW-1:0]   tnew;
    logic [REGW-1:0] rs;
    logic [REGW-1:0] rt;
  } entry_t;

  function automatic logic [TW-1:0] sat_dec(
    input logic [TW-1:0] x
  );
    return (x == '0) ? '0 : x - 1'b1;
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// D-stage control word in; stall and forwarding selects out.
// master = datapath/decoder side, slave = hazard unit.
interface hazard_unit_if;
  import hazard_unit_pkg::*;

  logic [REGW-1:0] d_rs;
  logic [REGW-1:0] d_rt;
  logic [TW-1:0]   d_tuse_rs;
  logic [TW-1:0]   d_tuse_rt;
  logic            d_wen;
  logic [REGW-1:0] d_wdst;
  logic [TW-1:0]   d_tninit;
  logic            stall;
  logic [1:0]      fwd_d_rs;
  logic [1:0]      fwd_d_rt;
  logic [1:0]      fwd_e_rs;
  logic [1:0]      fwd_e_rt;

  modport master (
    output d_rs, d_rt, d_tuse_rs, d_tuse_rt,
    output d_wen, d_wdst, d_tninit,
    input  stall, fwd_d_rs, fwd_d_rt,
    input  fwd_e_rs, fwd_e_rt
  );

  modport slave (
    input  d_rs, d_rt, d_tuse_rs, d_tuse_rt,
    input  d_wen, d_wdst, d_tninit,
    output stall, fwd_d_rs, fwd_d_rt,
    output fwd_e_rs, fwd_e_rt
  );

endinterface

// File: rtl/hazard_unit_stage_reg.sv
// hazard_stage_reg: one in-flight writer entry (wen/dst/tnew, optional rs/rt).
// Ports: clk, reset_n (async low), bubble (load empty entry), d in, q out.
module hazard_stage_reg
  import hazard_unit_pkg::*;
#(
  parameter int TMODE = TN_KEEP,
  parameter bit SRC   = 1'b0
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   bubble,
  input  entry_t d,
  output entry_t q
);

  entry_t nxt;

  always_comb begin
    nxt = d;
    if (!SRC) begin
      nxt.rs = '0;
      nxt.rt = '0;
    end
    if (TMODE == TN_DEC) begin
      nxt.tnew = sat_dec(d.tnew);
    end else if (TMODE == TN_CLR) begin
      nxt.tnew = '0;
    end
    if (bubble) begin
      nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard unit: tracks E/M/W writers, stalls D, drives D/E forwarding selects.
// Ports: clk, reset_n, hz (slave). HAZARD_FWD_EN enables forwarding.
module hazard_unit
  import hazard_unit_pkg::*;
(
  input  logic     clk,
  input  logic     reset_n,
  hazard_unit_if.slave hz
);

  entry_t d_ent;
  entry_t e_q;
  entry_t m_q;
  entry_t w_q;
  logic   stall;

  always_comb begin
    d_ent      = '0;
    d_ent.wen  = hz.d_wen;
    d_ent.dst  = hz.d_wdst;
    d_ent.tnew = hz.d_tninit;
    d_ent.rs   = hz.d_rs;
    d_ent.rt   = hz.d_rt;
  end

  hazard_stage_reg #(.TMODE(TN_KEEP), .SRC(1'b1)) u_e (
    .clk    (clk),
    .reset_n(reset_n),
    .bubble (stall),
    .d      (d_ent),
    .q      (e_q)
  );

  hazard_stage_reg #(.TMODE(TN_DEC), .SRC(1'b0)) u_m (
    .clk    (clk),
    .reset_n(reset_n),
    .bubble (1'b0),
    .d      (e_q),
    .q      (m_q)
  );

  hazard_stage_reg #(.TMODE(TN_CLR), .SRC(1'b0)) u_w (
    .clk    (clk),
    .reset_n(reset_n),
    .bubble (1'b0),
    .d      (m_q),
    .q      (w_q)
  );

  function automatic logic hit(
    input entry_t          s,
    input logic [REGW-1:0] r
  );
    return s.wen && (s.dst == r) && (r != REG_ZERO);
  endfunction

`ifdef HAZARD_FWD_EN

  // {stall, select}; the nearest matching stage alone decides.
  function automatic logic [2:0] d_res(
    input logic [REGW-1:0] r,
    input logic [TW-1:0]   u,
    input entry_t          e,
    input entry_t          m,
    input entry_t          w
  );
    logic [2:0] res;
    res = '0;
    if (u == TUSE_NONE) begin
      res = '0;
    end else if (hit(e, r)) begin
      res = {e.tnew > u, (e.tnew == '0) ? FWD_E : FWD_GRF};
    end else if (hit(m, r)) begin
      res = {m.tnew > u, (m.tnew == '0) ? FWD_M : FWD_GRF};
    end else if (hit(w, r)) begin
      res = {w.tnew > u, (w.tnew == '0) ? FWD_W : FWD_GRF};
    end
    return res;
  endfunction

  function automatic logic [1:0] e_sel(
    input logic [REGW-1:0] r,
    input entry_t          m,
    input entry_t          w
  );
    logic [1:0] sel;
    sel = FWD_GRF;
    if (hit(m, r)) begin
      sel = (m.tnew == '0) ? FWD_M : FWD_GRF;
    end else if (hit(w, r)) begin
      sel = (w.tnew == '0) ? FWD_W : FWD_GRF;
    end
    return sel;
  endfunction

  logic [2:0] rs_res;
  logic [2:0] rt_res;

  always_comb begin
    rs_res = d_res(hz.d_rs, hz.d_tuse_rs, e_q, m_q, w_q);
    rt_res = d_res(hz.d_rt, hz.d_tuse_rt, e_q, m_q, w_q);
  end

  assign stall       = rs_res[2] | rt_res[2];
  assign hz.fwd_d_rs = rs_res[1:0];
  assign hz.fwd_d_rt = rt_res[1:0];
  assign hz.fwd_e_rs = e_sel(e_q.rs, m_q, w_q);
  assign hz.fwd_e_rt = e_sel(e_q.rt, m_q, w_q);

`else

  // Interlock: any in-flight writer of a read operand holds D.
  function automatic logic lock(
    input logic [REGW-1:0] r,
    input logic [TW-1:0]   u,
    input entry_t          e,
    input entry_t          m,
    input entry_t          w
  );
    return (u != TUSE_NONE) &&
           (hit(e, r) || hit(m, r) || hit(w, r));
  endfunction

  logic rs_stall;
  logic rt_stall;

  always_comb begin
    rs_stall = lock(hz.d_rs, hz.d_tuse_rs, e_q, m_q, w_q);
    rt_stall = lock(hz.d_rt, hz.d_tuse_rt, e_q, m_q, w_q);
  end

  assign stall       = rs_stall | rt_stall;
  assign hz.fwd_d_rs = FWD_GRF;
  assign hz.fwd_d_rt = FWD_GRF;
  assign hz.fwd_e_rs = FWD_GRF;
  assign hz.fwd_e_rt = FWD_GRF;

`endif

  assign hz.stall = stall;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed instruction streams with
// per-cycle expected {stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt} queued.
module tb_hazard_unit;
  import hazard_unit_pkg::*;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  hazard_unit_if bus ();

  hazard_unit dut (
    .clk    (clk),
    .reset_n(reset_n),
    .hz     (bus)
  );

  typedef struct packed {
    logic [4:0] rs;
    logic [1:0] urs;
    logic [4:0] rt;
    logic [1:0] urt;
    logic       wen;
    logic [4:0] wd;
    logic [1:0] tn;
    logic [8:0] exp;
  } step_t;

  logic [8:0] sb[$];
  logic [8:0] want;
  logic [8:0] got;
  int cmp = 0;
  int bad = 0;

  localparam logic [8:0] Z = 9'd0;
  localparam logic [8:0] S = 9'h100;

  function automatic logic [8:0] x(
    input logic s, input logic [1:0] a, input logic [1:0] b,
    input logic [1:0] c, input logic [1:0] d
  );
    return {s, a, b, c, d};
  endfunction

  function automatic step_t st(
    input logic [4:0] rs, input logic [1:0] urs,
    input logic [4:0] rt, input logic [1:0] urt,
    input logic wen, input logic [4:0] wd,
    input logic [1:0] tn, input logic [8:0] e
  );
    step_t s;
    s = '{rs, urs, rt, urt, wen, wd, tn, e};
    return s;
  endfunction

  function automatic step_t lw(input logic [4:0] d, input logic [8:0] e);
    return st(5'd0, 2'd1, 5'd0, 2'd3, 1'b1, d, 2'd2, e);
  endfunction

  function automatic step_t addu(
    input logic [4:0] d, input logic [4:0] s, input logic [4:0] t,
    input logic [8:0] e
  );
    return st(s, 2'd1, t, 2'd1, 1'b1, d, 2'd1, e);
  endfunction

  function automatic step_t ori(input logic [4:0] d, input logic [8:0] e);
    return st(5'd0, 2'd1, 5'd0, 2'd3, 1'b1, d, 2'd1, e);
  endfunction

  function automatic step_t beq(
    input logic [4:0] s, input logic [4:0] t, input logic [8:0] e
  );
    return st(s, 2'd0, t, 2'd0, 1'b0, 5'd0, 2'd0, e);
  endfunction

  function automatic step_t jr(input logic [4:0] s, input logic [8:0] e);
    return st(s, 2'd0, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, e);
  endfunction

  function automatic step_t jal(input logic [8:0] e);
    return st(5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd31, 2'd0, e);
  endfunction

  function automatic step_t nop(input logic [8:0] e);
    return st(5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, e);
  endfunction

  function automatic logic [8:0] obs();
    return {bus.stall, bus.fwd_d_rs, bus.fwd_d_rt,
            bus.fwd_e_rs, bus.fwd_e_rt};
  endfunction

  task automatic set_in(input step_t s);
    bus.d_rs      = s.rs;
    bus.d_tuse_rs = s.urs;
    bus.d_rt      = s.rt;
    bus.d_tuse_rt = s.urt;
    bus.d_wen     = s.wen;
    bus.d_wdst    = s.wd;
    bus.d_tninit  = s.tn;
  endtask

  task automatic drive(input step_t s);
    set_in(s);
    sb.push_back(s.exp);
  endtask

  task automatic flush();
    set_in(nop(Z));
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(lw(5'd1, Z));
    #2;
    want = sb.pop_front();
    got  = obs();
    cmp++;
    if (got !== want) begin
      bad++;
      $display("FAIL reset_idle got=%h want=%h", got, want);
    end
    @(posedge clk);
    #1;
    drive(beq(5'd1, 5'd0, Z));
    @(negedge clk);
    want = sb.pop_front();
    got  = obs();
    cmp++;
    if (got !== want) begin
      bad++;
      $display("FAIL reset_held got=%h want=%h", got, want);
    end
    #1;
    reset_n = 1'b1;
    sb.push_back(Z);
    #1;
    want = sb.pop_front();
    got  = obs();
    cmp++;
    if (got !== want) begin
      bad++;
      $display("FAIL reset_release got=%h want=%h", got, want);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_load_use();
    step_t q[$];
    flush();
    q.push_back(lw(5'd1, Z));
`ifdef HAZARD_FWD_EN
    q.push_back(addu(5'd2, 5'd1, 5'd3, S));
    q.push_back(addu(5'd2, 5'd1, 5'd3, Z));
    q.push_back(nop(x(0, 0, 0, 3, 0)));
    q.push_back(nop(Z));
`else
    repeat (3) q.push_back(addu(5'd2, 5'd1, 5'd3, S));
    q.push_back(addu(5'd2, 5'd1, 5'd3, Z));
    q.push_back(nop(Z));
`endif
    foreach (q[i]) begin
      drive(q[i]);
      @(negedge clk);
      want = sb.pop_front();
      got  = obs();
      cmp++;
      if (got !== want) begin
        bad++;
        $display("FAIL load_use[%0d] got=%h want=%h", i, got, want);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_load_branch();
    step_t q[$];
    flush();
    q.push_back(lw(5'd1, Z));
`ifdef HAZARD_FWD_EN
    repeat (2) q.push_back(beq(5'd1, 5'd0, S));
    q.push_back(beq(5'd1, 5'd0, x(0, 3, 0, 0, 0)));
`else
    repeat (3) q.push_back(beq(5'd1, 5'd0, S));
    q.push_back(beq(5'd1, 5'd0, Z));
`endif
    q.push_back(nop(Z));
    foreach (q[i]) begin
      drive(q[i]);
      @(negedge clk);
      want = sb.pop_front();
      got  = obs();
      cmp++;
      if (got !== want) begin
        bad++;
        $display("FAIL load_branch[%0d] got=%h want=%h", i, got, want);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_alu_jr();
    step_t q[$];
    flush();
    q.push_back(ori(5'd5, Z));
`ifdef HAZARD_FWD_EN
    q.push_back(jr(5'd5, S));
    q.push_back(jr(5'd5, x(0, 2, 0, 0, 0)));
    q.push_back(nop(x(0, 0, 0, 3, 0)));
    q.push_back(nop(Z));
`else
    repeat (3) q.push_back(jr(5'd5, S));
    q.push_back(jr(5'd5, Z));
    q.push_back(nop(Z));
`endif
    foreach (q[i]) begin
      drive(q[i]);
      @(negedge clk);
      want = sb.pop_front();
      got  = obs();
      cmp++;
      if (got !== want) begin
        bad++;
        $display("FAIL alu_jr[%0d] got=%h want=%h", i, got, want);
      end
      @(posedge clk);
      #1;
    end
    q.delete();
    flush();
    q.push_back(ori(5'd5, Z));
`ifdef HAZARD_FWD_EN
    q.push_back(addu(5'd6, 5'd5, 5'd0, Z));
    q.push_back(nop(x(0, 0, 0, 2, 0)));
`else
    repeat (3) q.push_back(addu(5'd6, 5'd5, 5'd0, S));
    q.push_back(addu(5'd6, 5'd5, 5'd0, Z));
`endif
    q.push_back(nop(Z));
    foreach (q[i]) begin
      drive(q[i]);
      @(negedge clk);
      want = sb.pop_front();
      got  = obs();
      cmp++;
      if (got !== want) begin
        bad++;
        $display("FAIL alu_addu[%0d] got=%h want=%h", i, got, want);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_jal_zero();
    step_t q[$];
    flush();
    q.push_back(jal(Z));
`ifdef HAZARD_FWD_EN
    q.push_back(jr(5'd31, x(0, 1, 0, 0, 0)));
    q.push_back(nop(x(0, 0, 0, 2, 0)));
`else
    repeat (3) q.push_back(jr(5'd31, S));
    q.push_back(jr(5'd31, Z));
`endif
    q.push_back(nop(Z));
    q.push_back(st(5'd0, 2'd1, 5'd0, 2'd3, 1'b1, 5'd0, 2'd1, Z));
    q.push_back(beq(5'd0, 5'd0, Z));
    q.push_back(beq(5'd0, 5'd0, Z));
    q.push_back(nop(Z));
    foreach (q[i]) begin
      drive(q[i]);
      @(negedge clk);
      want = sb.pop_front();
      got  = obs();
      cmp++;
      if (got !== want) begin
        bad++;
        $display("FAIL jal_zero[%0d] got=%h want=%h", i, got, want);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_nearest();
    step_t q[$];
    flush();
    q.push_back(addu(5'd4, 5'd0, 5'd0, Z));
    q.push_back(ori(5'd4, Z));
`ifdef HAZARD_FWD_EN
    q.push_back(beq(5'd4, 5'd0, S));
    q.push_back(beq(5'd4, 5'd0, x(0, 2, 0, 0, 0)));
    q.push_back(nop(x(0, 0, 0, 3, 0)));
`else
    repeat (3) q.push_back(beq(5'd4, 5'd0, S));
    q.push_back(beq(5'd4, 5'd0, Z));
`endif
    q.push_back(nop(Z));
    foreach (q[i]) begin
      drive(q[i]);
      @(negedge clk);
      want = sb.pop_front();
      got  = obs();
      cmp++;
      if (got !== want) begin
        bad++;
        $display("FAIL nearest[%0d] got=%h want=%h", i, got, want);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_both_operands();
    step_t q[$];
    flush();
    q.push_back(lw(5'd7, Z));
`ifdef HAZARD_FWD_EN
    q.push_back(addu(5'd8, 5'd7, 5'd7, S));
    q.push_back(addu(5'd8, 5'd7, 5'd7, Z));
    q.push_back(nop(x(0, 0, 0, 3, 3)));
    q.push_back(ori(5'd9, Z));
    q.push_back(ori(5'd10, Z));
    q.push_back(beq(5'd9, 5'd10, x(1, 2, 0, 0, 0)));
    q.push_back(beq(5'd9, 5'd10, x(0, 3, 2, 0, 0)));
    q.push_back(nop(x(0, 0, 0, 0, 3)));
`else
    repeat (3) q.push_back(addu(5'd8, 5'd7, 5'd7, S));
    q.push_back(addu(5'd8, 5'd7, 5'd7, Z));
    q.push_back(nop(Z));
    repeat (3) q.push_back(nop(Z));
    q.push_back(ori(5'd9, Z));
    q.push_back(ori(5'd10, Z));
    repeat (3) q.push_back(beq(5'd9, 5'd10, S));
    q.push_back(beq(5'd9, 5'd10, Z));
`endif
    q.push_back(nop(Z));
    foreach (q[i]) begin
      drive(q[i]);
      @(negedge clk);
      want = sb.pop_front();
      got  = obs();
      cmp++;
      if (got !== want) begin
        bad++;
        $display("FAIL both_ops[%0d] got=%h want=%h", i, got, want);
      end
      @(posedge clk);
      #1;
    end
  endtask

`ifdef HAZARD_FWD_EN
  task automatic test_tuse_none();
    step_t q[$];
    flush();
    q.push_back(lw(5'd1, Z));
    q.push_back(st(5'd1, 2'd3, 5'd1, 2'd3, 1'b0, 5'd0, 2'd0, Z));
    q.push_back(nop(Z));
    q.push_back(nop(Z));
    foreach (q[i]) begin
      drive(q[i]);
      @(negedge clk);
      want = sb.pop_front();
      got  = obs();
      cmp++;
      if (got !== want) begin
        bad++;
        $display("FAIL tuse_none[%0d] got=%h want=%h", i, got, want);
      end
      @(posedge clk);
      #1;
    end
  endtask
`endif

  task automatic test_reset_mid();
    flush();
    drive(lw(5'd1, Z));
    @(negedge clk);
    want = sb.pop_front();
    got  = obs();
    cmp++;
    if (got !== want) begin
      bad++;
      $display("FAIL rmid_lw got=%h want=%h", got, want);
    end
    @(posedge clk);
    #1;
    drive(beq(5'd1, 5'd0, S));
    @(negedge clk);
    want = sb.pop_front();
    got  = obs();
    cmp++;
    if (got !== want) begin
      bad++;
      $display("FAIL rmid_stall got=%h want=%h", got, want);
    end
    #1;
    reset_n = 1'b0;
    sb.push_back(Z);
    #1;
    want = sb.pop_front();
    got  = obs();
    cmp++;
    if (got !== want) begin
      bad++;
      $display("FAIL rmid_async got=%h want=%h", got, want);
    end
    #1;
    reset_n = 1'b1;
    sb.push_back(Z);
    #1;
    want = sb.pop_front();
    got  = obs();
    cmp++;
    if (got !== want) begin
      bad++;
      $display("FAIL rmid_release got=%h want=%h", got, want);
    end
    @(posedge clk);
    #1;
    drive(nop(Z));
    @(negedge clk);
    want = sb.pop_front();
    got  = obs();
    cmp++;
    if (got !== want) begin
      bad++;
      $display("FAIL rmid_after got=%h want=%h", got, want);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    set_in(nop(Z));
    test_reset();
    test_load_use();
    test_load_branch();
    test_alu_jr();
    test_jal_zero();
    test_nearest();
    test_both_operands();
`ifdef HAZARD_FWD_EN
    test_tuse_none();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
